// File: rtl/fx2lp_slave_fifo_stream_out.sv
// FX2LP slave-FIFO EP2 reader: packs OUT bytes into 16-bit words behind a FWFT word FIFO.
// Optional FX2_STREAM_OUT_BYTE_SWAP_EN selects big-endian packing (first byte in m_data[15:8]).
module fx2lp_slave_fifo_stream_out #(
  parameter int DEPTH = 16,
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       fdata,
  input  logic             flaga,
  output logic [1:0]       faddr,
  output logic             sloe,
  output logic             slrd,
  output logic             slwr,
  output logic             pkt_end,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LVL_W-1:0] level,
  output logic             byte_pending
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OE   = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    low_byte;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_go;
  logic          push;
  logic          pop;
  logic [15:0]   push_word;

  assign faddr   = 2'b00;
  assign slwr    = 1'b1;
  assign pkt_end = 1'b1;

  // Leaving room for one more word (two bytes) means a started word can always complete.
  assign rd_go = (state == READ) && flaga && enable && (level <= LVL_W'(DEPTH - 2));
  assign slrd  = ~rd_go;
  assign sloe  = (state == IDLE);

  assign push    = rd_go && byte_pending;
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];

`ifdef FX2_STREAM_OUT_BYTE_SWAP_EN
  assign push_word = {low_byte, fdata};
`else
  assign push_word = {fdata, low_byte};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && flaga) state_nxt = OE;
      OE:      state_nxt = READ;
      READ:    if (!flaga || !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A half-finished word is kept across IDLE; only reset discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_pending <= 1'b0;
      low_byte     <= 8'h00;
    end else if (rd_go) begin
      if (!byte_pending) begin
        low_byte     <= fdata;
        byte_pending <= 1'b1;
      end else begin
        byte_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2lp_slave_fifo_stream_out.sv
// Directed bench for fx2lp_slave_fifo_stream_out: an FX2 EP2 source model feeds bytes on slrd,
// and every popped word is compared in order against the bytes the source handed out.
module tb_fx2lp_slave_fifo_stream_out;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [7:0]       fdata;
  logic             flaga;
  logic [1:0]       faddr;
  logic             sloe;
  logic             slrd;
  logic             slwr;
  logic             pkt_end;
  logic [15:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic [LVL_W-1:0] level;
  logic             byte_pending;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0]  stream [512];
  int          src_idx   = 0;
  int          src_limit = 0;
  logic [15:0] exp_q [$];
  logic        mdl_pending = 1'b0;
  logic [7:0]  mdl_low = 8'h00;
  logic [15:0] pop_log [64];
  int          pop_count  = 0;
  int          read_count = 0;
  int          max_level  = 0;

  fx2lp_slave_fifo_stream_out #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fdata(fdata), .flaga(flaga),
    .faddr(faddr), .sloe(sloe), .slrd(slrd), .slwr(slwr), .pkt_end(pkt_end),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .byte_pending(byte_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
`ifdef FX2_STREAM_OUT_BYTE_SWAP_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  task automatic updateSource();
    flaga = (src_idx < src_limit);
    fdata = stream[src_idx[8:0]];
  endtask

  // One clock: sample at the falling edge, then let the source advance after the rising edge.
  task automatic applyStimulus(input logic ready_val, output logic did_read);
    logic        rd;
    logic        pp;
    logic [15:0] obs;
    logic [15:0] w;
    logic [7:0]  b;
    m_ready = ready_val;
    @(negedge clk);
    rd  = ~slrd;
    pp  = m_valid & m_ready;
    obs = m_data;
    if (int'(level) > max_level) max_level = int'(level);
    if (pp) begin
      checkOutput("pop_level_vs_model", 32'(int'(level)), 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (pop_count < 64) pop_log[pop_count] = obs;
        pop_count++;
        checkOutput("pop_word", {16'h0, obs}, {16'h0, w});
      end
    end
    if (rd) begin
      checkOutput("read_only_with_data", {31'h0, flaga}, 32'h1);
      read_count++;
      b = stream[src_idx[8:0]];
      if (mdl_pending) begin
        exp_q.push_back(pack(mdl_low, b));
        mdl_pending = 1'b0;
      end else begin
        mdl_low     = b;
        mdl_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rd) src_idx++;
    updateSource();
    did_read = rd;
  endtask

  initial begin
    logic rd;
    int   first_low;
    int   base;
    int   reads0;
    int   n;

    for (int i = 0; i < 512; i++) begin
      if (i < 4) stream[i] = 8'((i + 1) * 8'h11);
      else       stream[i] = 8'(i * 37 + 5);
    end

    reset   = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    updateSource();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_faddr",   {30'h0, faddr},   32'h0);
    checkOutput("rst_sloe",    {31'h0, sloe},    32'h1);
    checkOutput("rst_slrd",    {31'h0, slrd},    32'h1);
    checkOutput("rst_slwr",    {31'h0, slwr},    32'h1);
    checkOutput("rst_pkt_end", {31'h0, pkt_end}, 32'h1);
    checkOutput("rst_m_valid", {31'h0, m_valid}, 32'h0);
    checkOutput("rst_level",   32'(level),       32'h0);
    checkOutput("rst_pending", {31'h0, byte_pending}, 32'h0);
    reset = 1'b0;

    // flaga held high with enable low must never strobe slrd
    src_limit = 512;
    updateSource();
    read_count = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, rd);
    checkOutput("disabled_reads", 32'(read_count), 32'h0);
    checkOutput("disabled_sloe",  {31'h0, sloe},   32'h1);

    // four bytes 11 22 33 44
    $display("[TB] basic packing");
    src_limit = 4;
    updateSource();
    enable     = 1'b1;
    read_count = 0;
    pop_count  = 0;
    first_low  = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, rd);
      if (rd && first_low < 0) first_low = i;
    end
    checkOutput("startup_latency", 32'(first_low), 32'd2);
    checkOutput("basic_reads",     32'(read_count), 32'd4);
    checkOutput("basic_pops",      32'(pop_count),  32'd2);
`ifdef FX2_STREAM_OUT_BYTE_SWAP_EN
    checkOutput("word0", {16'h0, pop_log[0]}, 32'h1122);
    checkOutput("word1", {16'h0, pop_log[1]}, 32'h3344);
`else
    checkOutput("word0", {16'h0, pop_log[0]}, 32'h2211);
    checkOutput("word1", {16'h0, pop_log[1]}, 32'h4433);
`endif
    checkOutput("basic_idle_sloe", {31'h0, sloe}, 32'h1);

    // backpressure with an endless source
    $display("[TB] level throttle");
    src_limit = 512;
    updateSource();
    read_count = 0;
    max_level  = 0;
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, rd);
    checkOutput("stall_reads",  32'(read_count), 32'(2 * (DEPTH - 1)));
    checkOutput("stall_level",  32'(level),      32'(DEPTH - 1));
    checkOutput("stall_slrd",   {31'h0, slrd},   32'h1);
    checkOutput("stall_sloe",   {31'h0, sloe},   32'h0);
    checkOutput("stall_max_ok", {31'h0, (max_level <= DEPTH - 1)}, 32'h1);
    enable    = 1'b0;
    src_limit = src_idx;
    updateSource();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, rd);
    checkOutput("drain_level", 32'(level),        32'h0);
    checkOutput("drain_model", 32'(exp_q.size()), 32'h0);

    // three bytes, source dries up, fourth byte later
    $display("[TB] partial word");
    base      = src_idx;
    src_limit = src_idx + 3;
    updateSource();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, rd);
    checkOutput("partial_pending", {31'h0, byte_pending}, 32'h1);
    checkOutput("partial_level",   32'(level),            32'h1);
    checkOutput("partial_sloe",    {31'h0, sloe},         32'h1);
    src_limit = src_idx + 1;
    updateSource();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, rd);
    checkOutput("complete_level",   32'(level),            32'h2);
    checkOutput("complete_pending", {31'h0, byte_pending}, 32'h0);
    pop_count = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, rd);
    checkOutput("partial_word1", {16'h0, pop_log[1]},
                {16'h0, pack(stream[base + 2], stream[base + 3])});

    // continuous stream with m_ready toggling every cycle
    $display("[TB] toggled ready");
    src_limit = 512;
    updateSource();
    max_level = 0;
    reads0    = read_count;
    for (int i = 0; i < 80; i++) applyStimulus(logic'(i % 2), rd);
    checkOutput("toggle_max_ok",   {31'h0, (max_level <= DEPTH - 1)}, 32'h1);
    checkOutput("toggle_progress", {31'h0, (read_count - reads0 > 40)}, 32'h1);
    enable    = 1'b0;
    src_limit = src_idx;
    updateSource();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, rd);
    checkOutput("toggle_drain_level", 32'(level),        32'h0);
    checkOutput("toggle_drain_model", 32'(exp_q.size()), 32'h0);
    checkOutput("toggle_pending",     {31'h0, byte_pending}, {31'h0, mdl_pending});

    // reset mid-word with five words queued
    $display("[TB] reset mid-word");
    n         = mdl_pending ? 10 : 11;
    src_limit = src_idx + n;
    updateSource();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, rd);
    checkOutput("pre_rst_level",   32'(level),            32'd5);
    checkOutput("pre_rst_pending", {31'h0, byte_pending}, 32'h1);
    enable = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mdl_pending = 1'b0;
    checkOutput("mid_rst_level",   32'(level),            32'h0);
    checkOutput("mid_rst_valid",   {31'h0, m_valid},      32'h0);
    checkOutput("mid_rst_pending", {31'h0, byte_pending}, 32'h0);
    checkOutput("mid_rst_sloe",    {31'h0, sloe},         32'h1);

    // the discarded byte must not leak into the next word
    src_limit = src_idx + 2;
    updateSource();
    enable    = 1'b1;
    pop_count = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, rd);
    checkOutput("post_rst_pops", 32'(pop_count), 32'h1);
    checkOutput("post_rst_word", {16'h0, pop_log[0]},
                {16'h0, pack(stream[src_idx - 2], stream[src_idx - 1])});

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fx2lp_slave_fifo_stream_out.md
# fx2lp_slave_fifo_stream_out

Reads bytes from the FX2LP slave FIFO OUT endpoint (EP2, host→FPGA). This is the receive-direction partner of the stream-IN writer. Consecutive bytes are packed into 16-bit words, and the words are buffered in an internal first-word-fall-through FIFO. Downstream logic (FFT input path) drains the FIFO over a valid/ready handshake, and the block throttles SLRD so that no byte is ever lost.

## Interface
Parameters:
- DEPTH, default 16: word-FIFO depth, in 16-bit entries. Must be a power of two, at least 4.
- LVL_W, default 5: width of `level`. Equals log2(DEPTH)+1.

Ports:
- clk  in  1  FX2LP IFCLK domain; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  streaming permitted while high.
- fdata  in  8  FX2LP FD[7:0].
- flaga  in  1  EP2 empty flag, active-low: 1 means data is available.
- faddr  out  2  FIFO address; constant 2'b00 (EP2).
- sloe  out  1  FIFO output enable, active-low.
- slrd  out  1  FIFO read strobe, active-low.
- slwr  out  1  constant 1 (no writes).
- pkt_end  out  1  constant 1.
- m_data  out  16  word at the FIFO head.
- m_valid  out  1  FIFO is non-empty.
- m_ready  in  1  downstream accepts the word when m_valid & m_ready.
- level  out  LVL_W  current word count.
- byte_pending  out  1  the packer holds a first byte.

## Operation
- There are three FSM states.
- IDLE:
  - Outputs: sloe=1, slrd=1.
  - Go to OE when enable & flaga.
- OE:
  - Outputs: sloe=0, slrd=1. This is a one-cycle bus turnaround.
  - Always go to READ next.
- READ:
  - sloe=0.
  - Read strobe: rd_go = flaga & enable & (level <= DEPTH-2), and slrd = ~rd_go (combinational).
  - Go to IDLE when flaga==0 or enable==0.
  - Stay in READ while only stalled by the level condition; sloe stays asserted in that case.
- Byte capture:
  - On every edge with rd_go=1, fdata is captured.
  - If byte_pending=0, the byte goes into the low-byte register and byte_pending becomes 1.
  - Otherwise the word {fdata, low_byte} is pushed and byte_pending becomes 0.
- Word FIFO:
  - Circular buffer of DEPTH entries with wrapping pointers.
  - A pop occurs when m_valid & m_ready.
  - Push and pop in the same cycle leave level unchanged.
  - A push while full cannot occur (guaranteed by the level throttle); a pop while empty is ignored.
- A partial word (byte_pending=1) survives enable deassertion and a return to IDLE. It completes with the next byte read and is never flushed or dropped, except by reset.
- Reset: clears state (IDLE), pointers, level, byte_pending and the low-byte register.

## Timing
- Reset values:
  - faddr=00, sloe=1, slrd=1, slwr=1, pkt_end=1.
  - m_valid=0, level=0, byte_pending=0.
  - m_data is don't-care while m_valid=0.
- Startup: from IDLE with flaga=1 and enable=1, the first slrd low occurs 2 cycles later (IDLE→OE→READ).
- Sustained throughput: one byte per clock while flaga=1 and space is available.
- Latency: the word appears on m_data with m_valid=1 in the cycle after the edge that captured its second byte.
- slrd reacts combinationally to flaga and level within the same cycle. There is no over-read when flaga falls.
- Reset has priority over all activity. Asserting reset mid-word discards the pending byte and the whole FIFO contents.

## Configuration
- Macro: FX2_STREAM_OUT_BYTE_SWAP_EN.
- Defined: the first byte read becomes m_data[15:8] and the second becomes m_data[7:0] (big-endian packing).
- Undefined (default): the first byte is m_data[7:0] (little-endian).
- Nothing else changes.

## Test plan
- Reset → all outputs at the listed reset values; a held flaga=1 with enable=0 produces no slrd pulse.
- enable=1, flaga=1, bytes 0x11,0x22,0x33,0x44 → slrd first low 2 cycles after enable; words 0x2211 then 0x4433 on m_data (0x1122, 0x3344 with the macro defined).
- m_ready=0 and an endless source (flaga=1) → exactly 2·(DEPTH-1) bytes read; level stops at DEPTH-1; slrd held high afterwards; sloe stays 0.
- Source supplies 3 bytes, then flaga=0 → FSM returns to IDLE with byte_pending=1 and level=1. Later a 4th byte arrives → the second word equals {byte4, byte3}.
- m_ready toggled every cycle during continuous streaming → level never exceeds DEPTH-1; the output sequence matches the input byte order exactly, with no drops or duplicates.
- reset pulsed with byte_pending=1 and level=5 → next cycle level=0, m_valid=0, byte_pending=0, sloe=1.
